// File: rtl/fetch_queue_if.sv
// Fetch queue bus: the instruction memory port, the redirect request and the decode-side handshake.
// The master modport belongs to fetch_queue. The slave modport belongs to the memory/decode side.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          redirect;
  logic [31:0]   redirect_pc;
  logic [31:0]   im_addr;
  logic [31:0]   im_data;
  logic          out_valid;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic          out_ready;
  logic [CW-1:0] count;

  modport master (
    input  redirect,
    input  redirect_pc,
    input  im_data,
    input  out_ready,
    output im_addr,
    output out_valid,
    output out_instr,
    output out_pc,
    output count
  );

  modport slave (
    output redirect,
    output redirect_pc,
    output im_data,
    output out_ready,
    input  im_addr,
    input  out_valid,
    input  out_instr,
    input  out_pc,
    input  count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: sequential fetch from a combinational-read memory into DEPTH {pc, instr} entries.
// Optional FETCH_QUEUE_BYPASS_EN forwards the live fetch to decode whenever the queue is empty.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input logic          clk,
  input logic          rst,
  fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic             queue_empty;
  logic             queue_full;
  logic             pop;
  logic             store_pop;
  logic             fetch_en;
  logic             write_en;
  logic             bypass_take;
  logic [DEPTH-1:0] entry_we;
  logic [31:0]      head_pc;
  logic [31:0]      head_instr;

  assign queue_empty = (count_reg == '0);
  assign queue_full  = (count_reg == FULL_COUNT);
  assign head_pc     = pc_mem[rd_ptr_reg];
  assign head_instr  = instr_mem[rd_ptr_reg];

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass_active;

  // An empty queue presents the instruction being fetched right now.
  assign bypass_active = queue_empty & ~bus.redirect;
  assign bypass_take   = bypass_active & bus.out_ready;
  assign bus.out_valid = ~queue_empty | bypass_active;
  assign bus.out_pc    = bypass_active ? bus.im_addr : head_pc;
  assign bus.out_instr = bypass_active ? bus.im_data : head_instr;
`else
  assign bypass_take   = 1'b0;
  assign bus.out_valid = ~queue_empty;
  assign bus.out_pc    = head_pc;
  assign bus.out_instr = head_instr;
`endif

  assign bus.im_addr = fetch_pc_reg;
  assign bus.count   = count_reg;

  // A bypassed consume counts as a pop of the handshake but never touches storage.
  assign pop       = bus.out_valid & bus.out_ready & ~bus.redirect;
  assign store_pop = pop & ~queue_empty;
  assign fetch_en  = ~bus.redirect & (~queue_full | pop);
  assign write_en  = fetch_en & ~bypass_take;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_we
    assign entry_we[gi] = write_en & (wr_ptr_reg == AW'(gi));
  end

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    if (bus.redirect) begin
      fetch_pc_next = {bus.redirect_pc[31:2], 2'b00};
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      count_next    = '0;
    end else begin
      if (fetch_en) begin
        fetch_pc_next = fetch_pc_reg + 32'd4;
      end
      if (write_en) begin
        wr_ptr_next = wr_ptr_reg + AW'(1);
      end
      if (store_pop) begin
        rd_ptr_next = rd_ptr_reg + AW'(1);
      end
      count_next = count_reg + CW'(write_en) - CW'(store_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_reg <= RESET_PC;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
    end
  end

  // Entries are cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entry_we[i]) begin
          pc_mem[i]    <= fetch_pc_reg;
          instr_mem[i] <= bus.im_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed steps plus a random phase, checked against a queue-based model.
// The memory returns addr ^ 32'hA5A5_A5A5.
module tb_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] KEY      = 32'hA5A5_A5A5;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();
  assign bus.im_data = bus.im_addr ^ KEY;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mq[$];
  logic [31:0] mpc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs, compare against the model, advance the model and the clock.
  task automatic step(input logic rdy, input logic redir, input logic [31:0] rpc);
    logic        exp_valid;
    logic [31:0] exp_pc;
    bit          did_pop;
    bus.out_ready   = rdy;
    bus.redirect    = redir;
    bus.redirect_pc = rpc;
    #1;
    exp_valid = (mq.size() != 0) || (BYP && !redir);
    exp_pc    = (mq.size() != 0) ? mq[0] : mpc;
    chk("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_valid});
    chk("count", {29'b0, bus.count}, mq.size());
    chk("im_addr", bus.im_addr, mpc);
    if (exp_valid) begin
      chk("out_pc", bus.out_pc, exp_pc);
      chk("out_instr", bus.out_instr, exp_pc ^ KEY);
    end
    $display("t=%0t rdy=%0b redir=%0b im_addr=%h valid=%0b out_pc=%h count=%0d",
             $time, rdy, redir, bus.im_addr, bus.out_valid, bus.out_pc, bus.count);
    if (redir) begin
      mq.delete();
      mpc = {rpc[31:2], 2'b00};
    end else if (BYP && mq.size() == 0 && rdy) begin
      mpc = mpc + 32'd4;
    end else begin
      did_pop = (mq.size() != 0) && rdy;
      if (did_pop) void'(mq.pop_front());
      if (mq.size() < DEPTH) begin
        mq.push_back(mpc);
        mpc = mpc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values();
    chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_count", {29'b0, bus.count}, 32'd0);
    chk("rst_im_addr", bus.im_addr, RESET_PC);
    chk("rst_out_pc", bus.out_pc, 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'd0);
  endtask

  initial begin
    logic        r_rdy;
    logic        r_redir;
    logic [31:0] r_pc;
    bus.out_ready   = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'd0;
    mpc = RESET_PC;

    // Reset state, then stream with decode always ready.
    repeat (2) @(posedge clk);
    #1;
    chk_reset_values();
    rst = 1'b1;
    repeat (6) step(1'b1, 1'b0, 32'd0);

    // Asynchronous reset mid-cycle while streaming.
    #3;
    rst = 1'b0;
    #1;
    chk_reset_values();
    mq.delete();
    mpc = RESET_PC;
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Stall: the queue fills and fetch holds.
    repeat (10) step(1'b0, 1'b0, 32'd0);
    chk("full_count", {29'b0, bus.count}, 32'd4);
    chk("full_im_addr", bus.im_addr, 32'h0000_3010);
    step(1'b1, 1'b0, 32'd0);
    chk("full_pp_count", {29'b0, bus.count}, 32'd4);
    chk("full_pp_im_addr", bus.im_addr, 32'h0000_3014);
    repeat (6) step(1'b1, 1'b0, 32'd0);

    // Redirect with three entries buffered.
    step(1'b0, 1'b1, 32'h0000_2000);
    repeat (3) step(1'b0, 1'b0, 32'd0);
    chk("pre_redir_count", {29'b0, bus.count}, 32'd3);
    step(1'b1, 1'b1, 32'h0000_3103);
    chk("redir_count", {29'b0, bus.count}, 32'd0);
    chk("redir_im_addr", bus.im_addr, 32'h0000_3100);
    step(1'b0, 1'b0, 32'd0);
    chk("redir_out_pc", bus.out_pc, 32'h0000_3100);

    // Fetch address wraps past the top of memory.
    step(1'b1, 1'b1, 32'hFFFF_FFF6);
    repeat (6) step(1'b1, 1'b0, 32'd0);

    // Random handshake and redirect traffic.
    for (int i = 0; i < 400; i++) begin
      r_rdy   = ($urandom_range(0, 3) != 0);
      r_redir = ($urandom_range(0, 15) == 0);
      r_pc    = $urandom_range(0, 1) ? $urandom : (32'hFFFF_FFE0 | ($urandom & 32'h1F));
      step(r_rdy, r_redir, r_pc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
